meta_info_streamer: RTL and testbench

Sequencer that walks the per-design metadata ROM (design select 5) and streams every string over a UART, so one serial capture shows the whole chip's project list without bit-banging the 12 input pins. It drives the ROM's 12-bit address input `{proj_idx[5:0], chr_idx[5:0]}` and consumes the 8-bit character output. For each project it sends characters up to the NUL terminator, then a newline (0x0A).

---
 rtl/meta_info_streamer.sv | 149 ++++++++++++++
 tb/tb_meta_info_streamer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/meta_info_streamer.sv
// meta_info_streamer: walks the metadata ROM and streams every project
// string over an 8N1 UART, one newline-terminated line per project.
module meta_info_streamer #(
    parameter int CLKS_PER_BIT  = 347,
    parameter int SETTLE_CYCLES = 6,
    parameter int NUM_PROJ      = 64,
    parameter int MAX_CHARS     = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_TX     = 2'd2;
    localparam logic [1:0] S_NEXT   = 2'd3;

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [5:0]    PROJ_LAST   = 6'(NUM_PROJ - 1);
    localparam logic [5:0]    CHR_LAST    = 6'(MAX_CHARS - 1);

    logic [1:0]    state_q, state_d;
    logic [5:0]    proj_q, proj_d;
    logic [5:0]    chr_q, chr_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          eol_q, eol_d;
    logic          tx_q, tx_d;

    assign rom_addr = {proj_q, chr_q};
    assign uart_tx  = tx_q;
    assign busy     = (state_q != S_IDLE);
    // Combinational so it overlaps the last busy cycle exactly once.
    assign done     = (state_q == S_NEXT) && eol_q && (proj_q == PROJ_LAST);

    // Next-state logic: ROM walk sequencing and UART bit serialisation.
    always_comb begin
        state_d  = state_q;
        proj_d   = proj_q;
        chr_d    = chr_q;
        settle_d = settle_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        eol_d    = eol_q;
        tx_d     = tx_q;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    proj_d   = '0;
                    chr_d    = '0;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    // NUL terminator turns into the line's newline.
                    byte_d  = (rom_data != 8'h00) ? rom_data : 8'h0A;
                    eol_d   = (rom_data == 8'h00);
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_TX;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_TX: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        state_d = S_NEXT;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        // Bit k+1 of the frame carries data bit k.
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : byte_q[bit_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_NEXT: begin
                if (eol_q) begin
                    if (proj_q == PROJ_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        proj_d   = proj_q + 6'd1;
                        chr_d    = '0;
                        settle_d = '0;
                        state_d  = S_SETTLE;
                    end
                end else if (chr_q == CHR_LAST) begin
                    // Truncated string: newline without a ROM read.
                    byte_d  = 8'h0A;
                    eol_d   = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_TX;
                end else begin
                    chr_d    = chr_q + 6'd1;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            proj_q   <= '0;
            chr_q    <= '0;
            settle_q <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            eol_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            proj_q   <= proj_d;
            chr_q    <= chr_d;
            settle_q <= settle_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            eol_q    <= eol_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_meta_info_streamer.sv
// tb_meta_info_streamer: directed bench for meta_info_streamer with a
// behavioural ROM, a UART receiver and an address logger.
module tb_meta_info_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        uart_tx;
    logic        busy;
    logic        done;

    logic [7:0]  rom [4096];
    logic [7:0]  rxq [$];
    logic [11:0] addrq [$];
    logic [11:0] last_addr;
    int          done_cnt;
    int          vecs;
    int          errs;
    int          cyc;

    // Dump of 3 projects: "AB" (43*3), "" (43), "XXXXXX" cut at 4 (43*4+41).
    localparam int DUMP_CYC = 3*43 + 43 + 4*43 + 41;

    meta_info_streamer #(
        .CLKS_PER_BIT (4),
        .SETTLE_CYCLES(2),
        .NUM_PROJ     (3),
        .MAX_CHARS    (4)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .start   (start),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    // UART receiver: mid-bit sampling on falling clock edges.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (2) @(negedge clk);
            b = '0;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (4) @(negedge clk);
            rxq.push_back(b);
        end
    end

    // Address logger and done counter.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy && rom_addr != last_addr) begin
            addrq.push_back(rom_addr);
            last_addr = rom_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_rom(input logic [7:0] c0, input logic [7:0] c1);
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = c0;
        rom[12'h001] = c1;
        for (int i = 0; i < 6; i++) rom[12'h080 + i] = 8'h58;
    endtask

    task automatic prep();
        rxq.delete();
        addrq.delete();
        last_addr = 12'hFFF;
        done_cnt  = 0;
    endtask

    task automatic wait_done(input bit toggle);
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (toggle) start = (cyc < 300) && ((cyc % 7) < 3);
        end
        start = 1'b0;
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] e [9]);
        chk({tag, "_count"}, rxq.size(), 9);
        for (int i = 0; i < 9; i++)
            chk(tag, (i < rxq.size()) ? rxq[i] : 8'hxx, e[i]);
    endtask

    initial begin
        logic [7:0] exp1 [9];
        logic [7:0] exp2 [9];
        logic [9:0] fr;
        bit         quiet;
        exp1 = '{8'h41, 8'h42, 8'h0A, 8'h0A, 8'h58,
                 8'h58, 8'h58, 8'h58, 8'h0A};
        exp2 = '{8'hA5, 8'h0A, 8'h0A, 8'h0A, 8'h58,
                 8'h58, 8'h58, 8'h58, 8'h0A};
        fr   = {1'b1, 8'hA5, 1'b0};
        vecs = 0;
        errs = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        load_rom(8'h41, 8'h42);
        prep();

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Dump 1: normal, empty and truncated strings.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("start_busy", busy, 1);
        chk("start_addr", rom_addr, 12'h000);
        wait_done(1'b0);
        chk("d1_done_cyc", cyc, DUMP_CYC);
        chk("d1_overlap", busy, 1);
        @(negedge clk);
        chk("d1_done_low", done, 0);
        chk("d1_busy_low", busy, 0);
        @(negedge clk);
        chk("d1_done_cnt", done_cnt, 1);
        chk_bytes("d1_byte", exp1);
        chk("d1_addr_cnt", addrq.size(), 8);
        chk("d1_addr0", addrq[0], 12'h000);
        chk("d1_addr2", addrq[2], 12'h002);
        chk("d1_addr3", addrq[3], 12'h040);
        chk("d1_addr4", addrq[4], 12'h080);
        chk("d1_addr7", addrq[7], 12'h083);

        // Dump 2: bit timing of 0xA5, and a ROM 0x0A kept in-line.
        load_rom(8'hA5, 8'h0A);
        prep();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        for (int k = 1; k <= 42; k++) begin
            if (k > 1) @(negedge clk);
            chk("a5_bit", uart_tx, (k <= 2) ? 1'b1 : fr[(k - 3) / 4]);
        end
        chk("a5_addr_hold", rom_addr, 12'h000);
        cyc = 42;
        wait_done(1'b0);
        chk("d2_done_cyc", cyc, DUMP_CYC);
        repeat (2) @(negedge clk);
        chk_bytes("d2_byte", exp2);

        // Dump 3: start toggled while busy is ignored.
        load_rom(8'h41, 8'h42);
        prep();
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        wait_done(1'b1);
        chk("d3_done_cyc", cyc, DUMP_CYC);
        repeat (20) @(negedge clk);
        chk("d3_done_cnt", done_cnt, 1);
        chk("d3_idle", busy, 0);
        chk_bytes("d3_byte", exp1);

        // Dump 4: reset during data bit 3 of 0x41.
        prep();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_bit3", uart_tx, 0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", uart_tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", rom_addr, 0);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("post_rst_quiet", quiet, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
